// File: rtl/cpuif_arbiter_2to1.sv
// Two-requester round-robin arbiter in front of a single cpuif regblock port.
// One transaction in flight at a time; a watchdog turns a missing ack into an error response.
module cpuif_arbiter_2to1 #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s0_req,
  input  logic                  s0_req_is_wr,
  input  logic [ADDR_WIDTH-1:0] s0_addr,
  input  logic [DATA_WIDTH-1:0] s0_wr_data,
  input  logic [DATA_WIDTH-1:0] s0_wr_biten,
  output logic                  s0_rsp_valid,
  output logic                  s0_rsp_err,
  output logic [DATA_WIDTH-1:0] s0_rsp_data,
  input  logic                  s1_req,
  input  logic                  s1_req_is_wr,
  input  logic [ADDR_WIDTH-1:0] s1_addr,
  input  logic [DATA_WIDTH-1:0] s1_wr_data,
  input  logic [DATA_WIDTH-1:0] s1_wr_biten,
  output logic                  s1_rsp_valid,
  output logic                  s1_rsp_err,
  output logic [DATA_WIDTH-1:0] s1_rsp_data,
  output logic                  m_cpuif_req,
  output logic                  m_cpuif_req_is_wr,
  output logic [ADDR_WIDTH-1:0] m_cpuif_addr,
  output logic [DATA_WIDTH-1:0] m_cpuif_wr_data,
  output logic [DATA_WIDTH-1:0] m_cpuif_wr_biten,
  input  logic                  m_cpuif_req_stall_wr,
  input  logic                  m_cpuif_req_stall_rd,
  input  logic                  m_cpuif_rd_ack,
  input  logic                  m_cpuif_rd_err,
  input  logic [DATA_WIDTH-1:0] m_cpuif_rd_data,
  input  logic                  m_cpuif_wr_ack,
  input  logic                  m_cpuif_wr_err,
  output logic                  stray_ack
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic            grant;
  logic            last_grant;
  logic [WD_W-1:0] wdog;

  logic                  next_grant;
  logic                  sel_is_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wr_data;
  logic [DATA_WIDTH-1:0] sel_wr_biten;
  logic                  stall;
  logic                  match_ack;
  logic                  wd_expired;
  logic                  go_resp;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  stray_hit;

  always_comb begin
    next_grant   = (s0_req && s1_req) ? ~last_grant : s1_req;
    sel_is_wr    = next_grant ? s1_req_is_wr : s0_req_is_wr;
    sel_addr     = next_grant ? s1_addr      : s0_addr;
    sel_wr_data  = next_grant ? s1_wr_data   : s0_wr_data;
    sel_wr_biten = next_grant ? s1_wr_biten  : s0_wr_biten;

    stall      = m_cpuif_req_is_wr ? m_cpuif_req_stall_wr : m_cpuif_req_stall_rd;
    match_ack  = m_cpuif_req_is_wr ? m_cpuif_wr_ack : m_cpuif_rd_ack;
    wd_expired = (wdog == WD_LIMIT);

    // A matching ack on the expiry cycle completes normally rather than timing out.
    go_resp   = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    if (state == ISSUE && wd_expired) begin
      go_resp  = 1'b1;
      resp_err = 1'b1;
    end else if (state == WAIT) begin
      if (match_ack) begin
        go_resp   = 1'b1;
        resp_err  = m_cpuif_req_is_wr ? m_cpuif_wr_err : m_cpuif_rd_err;
        resp_data = m_cpuif_req_is_wr ? '0 : m_cpuif_rd_data;
      end else if (wd_expired) begin
        go_resp  = 1'b1;
        resp_err = 1'b1;
      end
    end

    if (state == WAIT) begin
      stray_hit = m_cpuif_req_is_wr ? m_cpuif_rd_ack : m_cpuif_wr_ack;
    end else begin
      stray_hit = m_cpuif_rd_ack || m_cpuif_wr_ack;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      grant             <= 1'b0;
      last_grant        <= 1'b1;
      wdog              <= '0;
      m_cpuif_req       <= 1'b0;
      m_cpuif_req_is_wr <= 1'b0;
      m_cpuif_addr      <= '0;
      m_cpuif_wr_data   <= '0;
      m_cpuif_wr_biten  <= '0;
      s0_rsp_valid      <= 1'b0;
      s0_rsp_err        <= 1'b0;
      s0_rsp_data       <= '0;
      s1_rsp_valid      <= 1'b0;
      s1_rsp_err        <= 1'b0;
      s1_rsp_data       <= '0;
      stray_ack         <= 1'b0;
    end else begin
      s0_rsp_valid <= 1'b0;
      s0_rsp_err   <= 1'b0;
      s0_rsp_data  <= '0;
      s1_rsp_valid <= 1'b0;
      s1_rsp_err   <= 1'b0;
      s1_rsp_data  <= '0;

      if (stray_hit) begin
        stray_ack <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (s0_req || s1_req) begin
            grant             <= next_grant;
            last_grant        <= next_grant;
            wdog              <= '0;
            m_cpuif_req       <= 1'b1;
            m_cpuif_req_is_wr <= sel_is_wr;
            m_cpuif_addr      <= sel_addr;
            m_cpuif_wr_data   <= sel_wr_data;
            m_cpuif_wr_biten  <= sel_wr_biten;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          wdog <= wdog + WD_W'(1);
          if (wd_expired || !stall) begin
            m_cpuif_req <= 1'b0;
          end
          if (!wd_expired && !stall) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          wdog <= wdog + WD_W'(1);
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (go_resp) begin
        state <= RESP;
        if (grant) begin
          s1_rsp_valid <= 1'b1;
          s1_rsp_err   <= resp_err;
          s1_rsp_data  <= resp_data;
        end else begin
          s0_rsp_valid <= 1'b1;
          s0_rsp_err   <= resp_err;
          s0_rsp_data  <= resp_data;
        end
      end
    end
  end

endmodule
